// File: rtl/rt_ibex_window_pkg.sv
// Shared types and defaults for the register-window sequencer.
// Optional feature macro: RT_IBEX_WINDOW_PERF_EN (performance counters).
package rt_ibex_window_pkg;

    // Controller states
    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StSave,
        StPush,
        StPop,
        StRestore,
        StAck
    } window_ctrl_state_e;

    // Width of the hardware depth counter for a given window count.
    // At least one bit so that a two-window file still has a counter.
    function automatic int unsigned hw_depth_width(input int unsigned num_windows);
        return (num_windows > 2) ? $clog2(num_windows) : 1;
    endfunction

    localparam int unsigned DefaultNumRegisterWindows = 4;
    localparam int unsigned HwDepthWidth = hw_depth_width(DefaultNumRegisterWindows);

endpackage

// File: rtl/rt_ibex_window_perf.sv
// Saturating performance counters for the register-window sequencer.
// Only instantiated when RT_IBEX_WINDOW_PERF_EN is defined.
module rt_ibex_window_perf
    import rt_ibex_window_pkg::*;
#(
    parameter int unsigned DepthWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  ovf_entry_i,
    input  logic [DepthWidth-1:0] depth_i,
    output logic [31:0]           perf_push_o,
    output logic [31:0]           perf_ovf_o,
    output logic [DepthWidth-1:0] perf_max_depth_o
);

    logic [31:0]           push_cnt_q, push_cnt_d;
    logic [31:0]           ovf_cnt_q, ovf_cnt_d;
    logic [DepthWidth-1:0] max_depth_q, max_depth_d;

    // Next-state: counters stick at all-ones, high-water mark only rises
    always_comb begin
        push_cnt_d  = push_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        max_depth_d = max_depth_q;
        if (push_i && (push_cnt_q != '1)) begin
            push_cnt_d = push_cnt_q + 32'd1;
        end
        if (ovf_entry_i && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 32'd1;
        end
        if (depth_i > max_depth_q) begin
            max_depth_d = depth_i;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            push_cnt_q  <= '0;
            ovf_cnt_q   <= '0;
            max_depth_q <= '0;
        end else begin
            push_cnt_q  <= push_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            max_depth_q <= max_depth_d;
        end
    end

    assign perf_push_o      = push_cnt_q;
    assign perf_ovf_o       = ovf_cnt_q;
    assign perf_max_depth_o = max_depth_q;

endmodule

// File: rtl/rt_ibex_window_ctrl.sv
// Register-window sequencer: turns interrupt entry / mret requests into ordered
// save/push and pop/restore strobes, tracks nesting depth and window overflow.
// Optional feature macro: RT_IBEX_WINDOW_PERF_EN adds saturating perf counters.
module rt_ibex_window_ctrl
    import rt_ibex_window_pkg::*;
#(
    parameter int unsigned NumRegisterWindows = DefaultNumRegisterWindows,
    parameter int unsigned DepthWidth         = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  entry_req_i,
    input  logic                  exit_req_i,
    input  logic                  wb_idle_i,
    input  logic                  window_full_i,
    output logic                  ack_o,
    output logic                  busy_o,
    output logic                  save_csr_o,
    output logic                  increment_ptr_o,
    output logic                  decrement_ptr_o,
    output logic                  restore_csr_o,
    output logic                  overflow_o,
    output logic [DepthWidth-1:0] depth_o,
    output logic                  err_o
`ifdef RT_IBEX_WINDOW_PERF_EN
    ,
    output logic [31:0]           perf_push_o,
    output logic [31:0]           perf_ovf_o,
    output logic [DepthWidth-1:0] perf_max_depth_o
`endif
);

    localparam int unsigned HwW = hw_depth_width(NumRegisterWindows);
    localparam logic [HwW-1:0] HwMax = HwW'(NumRegisterWindows - 1);

    window_ctrl_state_e state_q, state_d;
    logic               entry_q, entry_d;   // direction of the request in flight
    logic [HwW-1:0]        hw_depth_q, hw_depth_d;
    logic [DepthWidth-1:0] ovf_depth_q, ovf_depth_d;
    logic                  err_q, err_d;

    logic [DepthWidth-1:0] depth;
    logic                  hw_room;
    logic                  depth_sat;
    logic                  windowed;
    logic                  ovf_nz;
    logic                  hw_nz;

    assign depth     = DepthWidth'(hw_depth_q) + ovf_depth_q;
    assign hw_room   = (hw_depth_q < HwMax);
    assign depth_sat = &depth;
    // A saturated total depth also refuses a push so depth_o cannot wrap
    assign windowed  = hw_room && !window_full_i && !depth_sat;
    assign ovf_nz    = |ovf_depth_q;
    assign hw_nz     = |hw_depth_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    // Next-state logic; entry wins over exit when both are pending in idle
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        unique case (state_q)
            StIdle: begin
                if (entry_req_i) begin
                    state_d = StDrain;
                    entry_d = 1'b1;
                end else if (exit_req_i) begin
                    state_d = StDrain;
                    entry_d = 1'b0;
                end
            end
            StDrain: begin
                if (wb_idle_i) begin
                    if (entry_q) begin
                        state_d = windowed ? StSave : StAck;
                    end else if (!ovf_nz && hw_nz) begin
                        state_d = StPop;
                    end else begin
                        state_d = StAck;
                    end
                end
            end
            StSave:    state_d = StPush;
            StPush:    state_d = StAck;
            StPop:     state_d = StRestore;
            StRestore: state_d = StAck;
            StAck:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output decode from state only
    always_comb begin
        ack_o           = 1'b0;
        save_csr_o      = 1'b0;
        increment_ptr_o = 1'b0;
        decrement_ptr_o = 1'b0;
        restore_csr_o   = 1'b0;
        busy_o          = (state_q != StIdle);
        unique case (state_q)
            StSave:    save_csr_o      = 1'b1;
            StPush:    increment_ptr_o = 1'b1;
            StPop:     decrement_ptr_o = 1'b1;
            StRestore: restore_csr_o   = 1'b1;
            StAck:     ack_o           = 1'b1;
            default:   ;
        endcase
    end

    // Depth and sticky error update; overflow levels are resolved as DRAIN completes
    always_comb begin
        hw_depth_d  = hw_depth_q;
        ovf_depth_d = ovf_depth_q;
        err_d       = err_q;
        if ((state_q == StDrain) && wb_idle_i) begin
            if (entry_q) begin
                // Register file claims full while we still see a free window
                if (hw_room && window_full_i) begin
                    err_d = 1'b1;
                end
                if (!windowed) begin
                    if (depth_sat) begin
                        err_d = 1'b1;
                    end else begin
                        ovf_depth_d = ovf_depth_q + 1'b1;
                    end
                end
            end else begin
                if (ovf_nz) begin
                    ovf_depth_d = ovf_depth_q - 1'b1;
                end else if (!hw_nz) begin
                    err_d = 1'b1;
                end
            end
        end
        if (state_q == StPush) begin
            hw_depth_d = hw_depth_q + 1'b1;
        end
        if (state_q == StPop) begin
            hw_depth_d = hw_depth_q - 1'b1;
        end
    end

    // Depth counters and error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hw_depth_q  <= '0;
            ovf_depth_q <= '0;
            err_q       <= 1'b0;
        end else begin
            hw_depth_q  <= hw_depth_d;
            ovf_depth_q <= ovf_depth_d;
            err_q       <= err_d;
        end
    end

    assign overflow_o = ovf_nz;
    assign depth_o    = depth;
    assign err_o      = err_q;

`ifdef RT_IBEX_WINDOW_PERF_EN
    logic ovf_entry;
    assign ovf_entry = (state_q == StDrain) && wb_idle_i && entry_q && !windowed;

    rt_ibex_window_perf #(
        .DepthWidth (DepthWidth)
    ) u_perf (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .push_i           (state_q == StPush),
        .ovf_entry_i      (ovf_entry),
        .depth_i          (depth),
        .perf_push_o      (perf_push_o),
        .perf_ovf_o       (perf_ovf_o),
        .perf_max_depth_o (perf_max_depth_o)
    );
`endif

endmodule

// File: tb/tb_rt_ibex_window_ctrl.sv
// Self-checking bench for rt_ibex_window_ctrl against a request-level model.
module tb_rt_ibex_window_ctrl;

    localparam int NW = 4;
    localparam int DW = 8;

    // Per-cycle observation code: {busy, ack, save, inc, dec, restore}
    localparam logic [5:0] CDrain   = 6'b100000;
    localparam logic [5:0] CSave    = 6'b101000;
    localparam logic [5:0] CPush    = 6'b100100;
    localparam logic [5:0] CPop     = 6'b100010;
    localparam logic [5:0] CRestore = 6'b100001;
    localparam logic [5:0] CAck     = 6'b110000;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          entry_req_i, exit_req_i, wb_idle_i, window_full_i;
    logic          ack_o, busy_o, save_csr_o, increment_ptr_o, decrement_ptr_o;
    logic          restore_csr_o, overflow_o, err_o;
    logic [DW-1:0] depth_o;
`ifdef RT_IBEX_WINDOW_PERF_EN
    logic [31:0]   perf_push_o, perf_ovf_o;
    logic [DW-1:0] perf_max_depth_o;
`endif

    rt_ibex_window_ctrl #(
        .NumRegisterWindows (NW),
        .DepthWidth         (DW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .entry_req_i     (entry_req_i),
        .exit_req_i      (exit_req_i),
        .wb_idle_i       (wb_idle_i),
        .window_full_i   (window_full_i),
        .ack_o           (ack_o),
        .busy_o          (busy_o),
        .save_csr_o      (save_csr_o),
        .increment_ptr_o (increment_ptr_o),
        .decrement_ptr_o (decrement_ptr_o),
        .restore_csr_o   (restore_csr_o),
        .overflow_o      (overflow_o),
        .depth_o         (depth_o),
        .err_o           (err_o)
`ifdef RT_IBEX_WINDOW_PERF_EN
        ,
        .perf_push_o      (perf_push_o),
        .perf_ovf_o       (perf_ovf_o),
        .perf_max_depth_o (perf_max_depth_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0;
    int nerr = 0;

    // Reference model: nesting split into windowed and overflowed levels
    int mdl_hw  = 0;
    int mdl_ovf = 0;
    bit mdl_err = 1'b0;

    logic [5:0] obs [64];
    logic [5:0] expv[64];
    int         obs_len;
    int         exp_len;

    function automatic logic [5:0] cur_code();
        return {busy_o, ack_o, save_csr_o, increment_ptr_o, decrement_ptr_o, restore_csr_o};
    endfunction

    // Expected strobe trace for one request, and model update
    task automatic model_req(input bit ent, input int stall, input bit full);
        exp_len = 0;
        for (int i = 0; i <= stall; i++) begin
            expv[exp_len] = CDrain;
            exp_len++;
        end
        if (ent) begin
            if (mdl_hw < NW - 1 && full) mdl_err = 1'b1;
            if (mdl_hw < NW - 1 && !full) begin
                expv[exp_len] = CSave;  exp_len++;
                expv[exp_len] = CPush;  exp_len++;
                mdl_hw++;
            end else if (mdl_hw + mdl_ovf == (1 << DW) - 1) begin
                mdl_err = 1'b1;
            end else begin
                mdl_ovf++;
            end
        end else begin
            if (mdl_ovf > 0) begin
                mdl_ovf--;
            end else if (mdl_hw > 0) begin
                expv[exp_len] = CPop;     exp_len++;
                expv[exp_len] = CRestore; exp_len++;
                mdl_hw--;
            end else begin
                mdl_err = 1'b1;
            end
        end
        expv[exp_len] = CAck;
        exp_len++;
    endtask

    // Drive one request from idle and record the per-cycle trace until ack
    task automatic run_req(input bit ent, input bit ext, input int stall, input bit full);
        int  cyc;
        bit  done;
        @(posedge clk_i); #1;
        entry_req_i   = ent;
        exit_req_i    = ext;
        window_full_i = full;
        wb_idle_i     = (stall == 0);
        obs_len = 0;
        cyc     = 0;
        done    = 1'b0;
        while (!done && cyc < 64) begin
            @(posedge clk_i); #1;
            cyc++;
            wb_idle_i = (cyc > stall);
            obs[obs_len] = cur_code();
            obs_len++;
            if (ack_o) begin
                done          = 1'b1;
                entry_req_i   = 1'b0;
                exit_req_i    = 1'b0;
                wb_idle_i     = 1'b1;
                window_full_i = 1'b0;
            end
        end
    endtask

    // Index of first trace difference, or -1 when traces agree
    function automatic int trace_diff();
        int n;
        n = (obs_len < exp_len) ? obs_len : exp_len;
        for (int i = 0; i < n; i++) begin
            if (obs[i] !== expv[i]) return i;
        end
        if (obs_len != exp_len) return n;
        return -1;
    endfunction

    task automatic test_reset();
        rst_ni        = 1'b0;
        entry_req_i   = 1'b0;
        exit_req_i    = 1'b0;
        wb_idle_i     = 1'b1;
        window_full_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        nvec++;
        if ({ack_o, busy_o, save_csr_o, increment_ptr_o, decrement_ptr_o, restore_csr_o,
             overflow_o, err_o} !== 8'h00) begin
            nerr++;
            $display("FAIL reset_outputs: got %b want 00000000", {ack_o, busy_o, save_csr_o,
                     increment_ptr_o, decrement_ptr_o, restore_csr_o, overflow_o, err_o});
        end
        nvec++;
        if (depth_o !== 8'd0) begin
            nerr++;
            $display("FAIL reset_depth: got %0d want 0", depth_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        nvec++;
        if (busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL reset_idle_busy: got %b want 0", busy_o);
        end
    endtask

    task automatic test_single_entry();
        int d;
        model_req(1'b1, 0, 1'b0);
        run_req(1'b1, 1'b0, 0, 1'b0);
        d = trace_diff();
        nvec++;
        if (d >= 0) begin
            nerr++;
            $display("FAIL single_entry_trace: cycle %0d got %b want %b (len %0d want %0d)",
                     d + 1, obs[d], expv[d], obs_len, exp_len);
        end
        nvec++;
        if (depth_o !== 8'(mdl_hw + mdl_ovf)) begin
            nerr++;
            $display("FAIL single_entry_depth: got %0d want %0d", depth_o, mdl_hw + mdl_ovf);
        end
    endtask

    task automatic test_drain_stall();
        int d;
        model_req(1'b1, 3, 1'b0);
        run_req(1'b1, 1'b0, 3, 1'b0);
        d = trace_diff();
        nvec++;
        if (d >= 0) begin
            nerr++;
            $display("FAIL drain_stall_trace: cycle %0d got %b want %b (len %0d want %0d)",
                     d + 1, obs[d], expv[d], obs_len, exp_len);
        end
        nvec++;
        if (obs_len !== 7) begin
            nerr++;
            $display("FAIL drain_stall_latency: got %0d want 7", obs_len);
        end
    endtask

    task automatic test_nesting();
        int d;
        // Return to depth 0 first so five entries land on 3 windows plus 2 overflows
        for (int i = 0; i < 2; i++) begin
            model_req(1'b0, 0, 1'b0);
            run_req(1'b0, 1'b1, 0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            model_req(1'b1, 0, (mdl_hw == NW - 1));
            run_req(1'b1, 1'b0, 0, (mdl_hw == NW - 1) && (mdl_ovf > 0 || i == 3));
            d = trace_diff();
            nvec++;
            if (d >= 0) begin
                nerr++;
                $display("FAIL nesting_trace[%0d]: cycle %0d got %b want %b", i, d + 1,
                         obs[d], expv[d]);
            end
        end
        nvec++;
        if (overflow_o !== 1'b1) begin
            nerr++;
            $display("FAIL nesting_overflow: got %b want 1", overflow_o);
        end
        nvec++;
        if (depth_o !== 8'd5) begin
            nerr++;
            $display("FAIL nesting_depth: got %0d want 5", depth_o);
        end
    endtask

    task automatic test_unwind();
        int d;
        for (int i = 0; i < 5; i++) begin
            model_req(1'b0, 0, 1'b0);
            run_req(1'b0, 1'b1, 0, 1'b0);
            d = trace_diff();
            nvec++;
            if (d >= 0) begin
                nerr++;
                $display("FAIL unwind_trace[%0d]: cycle %0d got %b want %b", i, d + 1,
                         obs[d], expv[d]);
            end
            nvec++;
            if (overflow_o !== (mdl_ovf != 0)) begin
                nerr++;
                $display("FAIL unwind_overflow[%0d]: got %b want %b", i, overflow_o,
                         (mdl_ovf != 0));
            end
        end
        nvec++;
        if (depth_o !== 8'd0) begin
            nerr++;
            $display("FAIL unwind_depth: got %0d want 0", depth_o);
        end
    endtask

    task automatic test_underflow();
        int d;
        model_req(1'b0, 0, 1'b0);
        run_req(1'b0, 1'b1, 0, 1'b0);
        d = trace_diff();
        nvec++;
        if (d >= 0) begin
            nerr++;
            $display("FAIL underflow_trace: cycle %0d got %b want %b (len %0d want %0d)",
                     d + 1, obs[d], expv[d], obs_len, exp_len);
        end
        nvec++;
        if (err_o !== 1'b1) begin
            nerr++;
            $display("FAIL underflow_err: got %b want 1", err_o);
        end
    endtask

    task automatic test_simultaneous();
        bit acked;
        bit popped;
        model_req(1'b1, 0, 1'b0);
        run_req(1'b1, 1'b0, 0, 1'b0);
        @(posedge clk_i); #1;
        entry_req_i = 1'b1;
        exit_req_i  = 1'b1;
        wb_idle_i   = 1'b1;
        acked = 1'b0;
        for (int i = 0; i < 20 && !acked; i++) begin
            @(posedge clk_i); #1;
            if (ack_o) acked = 1'b1;
        end
        entry_req_i = 1'b0;
        mdl_hw++;
        nvec++;
        if (!acked || depth_o !== 8'(mdl_hw)) begin
            nerr++;
            $display("FAIL simul_entry_first: ack %b depth %0d want ack 1 depth %0d", acked,
                     depth_o, mdl_hw);
        end
        @(posedge clk_i); #1;
        nvec++;
        if (busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL simul_idle_gap: busy got %b want 0", busy_o);
        end
        acked  = 1'b0;
        popped = 1'b0;
        for (int i = 0; i < 20 && !acked; i++) begin
            @(posedge clk_i); #1;
            if (decrement_ptr_o) popped = 1'b1;
            if (ack_o) acked = 1'b1;
        end
        exit_req_i = 1'b0;
        mdl_hw--;
        nvec++;
        if (!acked || !popped || depth_o !== 8'(mdl_hw)) begin
            nerr++;
            $display("FAIL simul_exit_second: ack %b pop %b depth %0d want 1 1 %0d", acked,
                     popped, depth_o, mdl_hw);
        end
        nvec++;
        if (err_o !== 1'b1) begin
            nerr++;
            $display("FAIL err_sticky: got %b want 1", err_o);
        end
    endtask

    task automatic test_reset_mid_push();
        bit seen;
        @(posedge clk_i); #1;
        entry_req_i = 1'b1;
        wb_idle_i   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk_i); #1;
            if (increment_ptr_o) seen = 1'b1;
        end
        nvec++;
        if (!seen) begin
            nerr++;
            $display("FAIL reset_push_reach: push seen %b want 1", seen);
        end
        rst_ni      = 1'b0;
        entry_req_i = 1'b0;
        @(posedge clk_i); #1;
        nvec++;
        if ({ack_o, busy_o, save_csr_o, increment_ptr_o, decrement_ptr_o, restore_csr_o,
             overflow_o, err_o, depth_o} !== 16'h0000) begin
            nerr++;
            $display("FAIL reset_mid_push: got %b want all zero", {ack_o, busy_o, save_csr_o,
                     increment_ptr_o, decrement_ptr_o, restore_csr_o, overflow_o, err_o,
                     depth_o});
        end
        rst_ni  = 1'b1;
        mdl_hw  = 0;
        mdl_ovf = 0;
        mdl_err = 1'b0;
    endtask

    task automatic test_random();
        int d;
        bit ent;
        int stall;
        bit full;
        for (int n = 0; n < 40; n++) begin
            ent   = ($urandom_range(0, 2) != 0);
            stall = $urandom_range(0, 3);
            full  = (mdl_hw == NW - 1) ? 1'b1 : ($urandom_range(0, 7) == 0);
            model_req(ent, stall, full);
            run_req(ent, !ent, stall, full);
            d = trace_diff();
            nvec++;
            if (d >= 0) begin
                nerr++;
                $display("FAIL random_trace[%0d]: cycle %0d got %b want %b (len %0d want %0d)",
                         n, d + 1, obs[d], expv[d], obs_len, exp_len);
            end
            nvec++;
            if (depth_o !== 8'(mdl_hw + mdl_ovf) || overflow_o !== (mdl_ovf != 0) ||
                err_o !== mdl_err) begin
                nerr++;
                $display("FAIL random_state[%0d]: depth %0d ovf %b err %b want %0d %b %b", n,
                         depth_o, overflow_o, err_o, mdl_hw + mdl_ovf, (mdl_ovf != 0),
                         mdl_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_drain_stall();
        test_nesting();
        test_unwind();
        test_underflow();
        test_simultaneous();
        test_reset_mid_push();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
